// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports (core C, loader L) and the data-RAM port.
// slave is the arbiter's view; master is the view of the requesters and the RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_lock;
  logic          c_gnt;
  logic          c_done;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_done;

  logic [DW-1:0] rdata;
  logic          busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_lock,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output c_gnt, c_done, l_gnt, l_done, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_lock,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  c_gnt, c_done, l_gnt, l_done, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core and the
// image loader, with a core lock and a fixed RAM read latency.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input logic           clock,
  input logic           reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          arb, pick_c, pick_l, elig_l;

  logic          own_l, last_l, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          c_gnt_q, l_gnt_q, c_done_q, l_done_q, busy_q, mem_en_q;
  logic          c_gnt_d, l_gnt_d, c_done_d, l_done_d, busy_d, mem_en_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Winner selection: the lock removes the loader; on a tie the port not served last wins.
  always_comb begin
    arb     = (state == IDLE) || (state == RESP);
    elig_l  = bus.l_req && !bus.c_lock;
    pick_c  = arb && bus.c_req && (!elig_l || last_l);
    pick_l  = arb && elig_l && !pick_c;
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE, RESP: state_d = (pick_c || pick_l) ? ISSUE : IDLE;
      ISSUE: begin
        if (we_q || (MEM_LAT == 1)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_gnt_d  = pick_c;
    l_gnt_d  = pick_l;
    mem_en_d = (state_d == ISSUE);
    busy_d   = (state_d == ISSUE) || (state_d == WAIT);
    c_done_d = (state_d == RESP) && !own_l;
    l_done_d = (state_d == RESP) && own_l;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_gnt_q  <= 1'b0;
      l_gnt_q  <= 1'b0;
      c_done_q <= 1'b0;
      l_done_q <= 1'b0;
      busy_q   <= 1'b0;
      mem_en_q <= 1'b0;
      own_l    <= 1'b0;
      last_l   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      c_gnt_q  <= c_gnt_d;
      l_gnt_q  <= l_gnt_d;
      c_done_q <= c_done_d;
      l_done_q <= l_done_d;
      busy_q   <= busy_d;
      mem_en_q <= mem_en_d;
      if (pick_c || pick_l) begin
        own_l   <= pick_l;
        last_l  <= pick_l;
        we_q    <= pick_l ? bus.l_we    : bus.c_we;
        addr_q  <= pick_l ? bus.l_addr  : bus.c_addr;
        wdata_q <= pick_l ? bus.l_wdata : bus.c_wdata;
      end
      // Read data is sampled on the edge into RESP and held until the next read.
      if ((state_d == RESP) && !we_q) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.c_gnt     = c_gnt_q;
  assign bus.l_gnt     = l_gnt_q;
  assign bus.c_done    = c_done_q;
  assign bus.l_done    = l_done_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a timeline-level reference model predicts
// grants, completions and read data for a MEM_LAT=1 instance; a MEM_LAT=3 instance gets directed checks.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LAT1 = 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clock = 1'b0;
  logic rst1_n, rst3_n;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u1 (.clock(clock), .reset_n(rst1_n), .bus(b1));
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u3 (.clock(clock), .reset_n(rst3_n), .bus(b3));

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h4A;
  endfunction

  // RAM behind u1: read data is valid during the strobe cycle.
  logic [7:0] ram1 [0:65535];
  bit         wm1  [0:65535];
  always @(posedge clock) begin
    if (b1.mem_en && b1.mem_we) begin
      ram1[b1.mem_addr] <= b1.mem_wdata;
      wm1[b1.mem_addr]  <= 1'b1;
    end
  end
  always_comb begin
    b1.mem_rdata = 8'hEE;
    if (b1.mem_en) b1.mem_rdata = wm1[b1.mem_addr] ? ram1[b1.mem_addr] : init_val(b1.mem_addr);
  end

  // RAM behind u3 (read-only here): data valid only two cycles after the strobe.
  logic [2:0]  age3;
  logic [15:0] a3;
  always @(posedge clock or negedge rst3_n) begin
    if (!rst3_n) begin
      age3 <= 3'd0;
      a3   <= 16'h0;
    end else if (b3.mem_en) begin
      age3 <= 3'd1;
      a3   <= b3.mem_addr;
    end else if (age3 != 3'd0 && age3 != 3'd7) begin
      age3 <= age3 + 3'd1;
    end
  end
  always_comb begin
    b3.mem_rdata = (age3 == 3'd2) ? init_val(a3) : 8'hEE;
  end

  int n_chk, n_pass;
  int cyc, free_cyc, gnt_cyc, done_cyc;
  bit own_l, p_we, last_l;
  logic [15:0] p_addr;
  logic [7:0]  p_wdata, rd_val, exp_rdata;
  logic [7:0]  mram [0:65535];
  bit          mwm  [0:65535];
  txn_t cq[$], lq[$];
  bit   gseq[$];
  bit   rnd_on, lock_mode, lock_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic txn_t mk(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom));
  endfunction

  task automatic compare1();
    bit eg, ed;
    eg = (cyc == gnt_cyc);
    ed = (cyc == done_cyc);
    if (ed && !p_we) exp_rdata = rd_val;
    check("c_gnt",  32'(b1.c_gnt),  32'(eg && !own_l));
    check("l_gnt",  32'(b1.l_gnt),  32'(eg && own_l));
    check("c_done", 32'(b1.c_done), 32'(ed && !own_l));
    check("l_done", 32'(b1.l_done), 32'(ed && own_l));
    check("busy",   32'(b1.busy),   32'(cyc >= gnt_cyc && cyc < done_cyc));
    check("mem_en", 32'(b1.mem_en), 32'(eg));
    check("rdata",  32'(b1.rdata),  32'(exp_rdata));
    if (eg) begin
      check("mem_we",   32'(b1.mem_we),   32'(p_we));
      check("mem_addr", 32'(b1.mem_addr), 32'(p_addr));
      if (p_we) check("mem_wdata", 32'(b1.mem_wdata), 32'(p_wdata));
    end
  endtask

  task automatic drive1();
    txn_t t;
    if (b1.c_gnt) begin
      gseq.push_back(1'b0);
      if (cq.size() != 0) t = cq.pop_front();
    end
    if (b1.l_gnt) begin
      gseq.push_back(1'b1);
      if (lq.size() != 0) t = lq.pop_front();
    end
    if (rnd_on) begin
      if (cq.size() == 0 && $urandom_range(0, 2) == 0) cq.push_back(rand_txn());
      if (lq.size() == 0 && $urandom_range(0, 2) == 0) lq.push_back(rand_txn());
      if ($urandom_range(0, 15) == 0) lock_v = ~lock_v;
    end
    if (lock_mode) lock_v = (cq.size() != 0);
    b1.c_lock = lock_v;
    t = (cq.size() != 0) ? cq[0] : '0;
    b1.c_req = (cq.size() != 0); b1.c_we = t.we; b1.c_addr = t.addr; b1.c_wdata = t.wdata;
    t = (lq.size() != 0) ? lq[0] : '0;
    b1.l_req = (lq.size() != 0); b1.l_we = t.we; b1.l_addr = t.addr; b1.l_wdata = t.wdata;
  endtask

  // Reference: serialized accesses on a cycle timeline; the completion cycle is also the next arbitration cycle.
  task automatic model1();
    bit ec, el;
    if (cyc >= free_cyc) begin
      ec = b1.c_req;
      el = b1.l_req && !b1.c_lock;
      if (ec || el) begin
        own_l  = el && (!ec || !last_l);
        last_l = own_l;
        if (own_l) begin p_we = b1.l_we; p_addr = b1.l_addr; p_wdata = b1.l_wdata; end
        else       begin p_we = b1.c_we; p_addr = b1.c_addr; p_wdata = b1.c_wdata; end
        gnt_cyc  = cyc + 1;
        done_cyc = gnt_cyc + (p_we ? 1 : LAT1);
        free_cyc = done_cyc;
        if (p_we) begin
          mram[p_addr] = p_wdata;
          mwm[p_addr]  = 1'b1;
        end else begin
          rd_val = mwm[p_addr] ? mram[p_addr] : init_val(p_addr);
        end
      end else begin
        free_cyc = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare1();
    drive1();
    model1();
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((cq.size() != 0 || lq.size() != 0 || cyc <= done_cyc) && n < maxc) begin
      tick();
      n++;
    end
    check("drain", 32'(cq.size() + lq.size()), 32'd0);
  endtask

  task automatic reset1();
    @(negedge clock);
    rst1_n = 1'b0;
    cq.delete(); lq.delete();
    lock_v = 1'b0; rnd_on = 1'b0; lock_mode = 1'b0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = 0; b1.c_wdata = 0; b1.c_lock = 0;
    b1.l_req = 0; b1.l_we = 0; b1.l_addr = 0; b1.l_wdata = 0;
    #1;
    check("rst_gnt",    32'({b1.c_gnt, b1.l_gnt}),   32'd0);
    check("rst_done",   32'({b1.c_done, b1.l_done}), 32'd0);
    check("rst_busy",   32'(b1.busy),     32'd0);
    check("rst_mem_en", 32'(b1.mem_en),   32'd0);
    check("rst_addr",   32'(b1.mem_addr), 32'd0);
    check("rst_rdata",  32'(b1.rdata),    32'd0);
    @(negedge clock);
    rst1_n = 1'b1;
    cyc = 0; free_cyc = 0; gnt_cyc = -10; done_cyc = -10;
    last_l = 1'b1; own_l = 1'b0; p_we = 1'b1; exp_rdata = 8'h00;
    gseq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit seen;
    n_chk = 0; n_pass = 0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    b3.c_req = 0; b3.c_we = 0; b3.c_addr = 0; b3.c_wdata = 0; b3.c_lock = 0;
    b3.l_req = 0; b3.l_we = 0; b3.l_addr = 0; b3.l_wdata = 0;
    repeat (2) @(negedge clock);
    rst3_n = 1'b1;

    // Core read of 0x0010 right after reset.
    reset1();
    cq.push_back(mk(1'b0, 16'h0010, 8'h00));
    tick(); tick();
    check("t1_gnt", 32'(b1.c_gnt), 32'd1);
    check("t1_mem_en", 32'(b1.mem_en), 32'd1);
    tick();
    check("t1_done", 32'(b1.c_done), 32'd1);
    check("t1_rdata", 32'(b1.rdata), 32'h5A);
    drain(10);

    // Loader write then core read of the same word.
    lq.push_back(mk(1'b1, 16'h0100, 8'h3C));
    drain(10);
    check("t2_ram", 32'(ram1[16'h0100]), 32'h3C);
    cq.push_back(mk(1'b0, 16'h0100, 8'h00));
    drain(10);
    check("t2_rdata", 32'(b1.rdata), 32'h3C);

    // Both ports requesting continuously: strict alternation starting with the core.
    reset1();
    for (int i = 0; i < 6; i++) begin
      cq.push_back(rand_txn());
      lq.push_back(rand_txn());
    end
    drain(100);
    check("alt_n", 32'(gseq.size()), 32'd12);
    check("alt_first", 32'(gseq[0]), 32'd0);
    for (int i = 1; i < gseq.size(); i++) check("alt", 32'(gseq[i]), 32'(!gseq[i-1]));

    // Lock held while the core has work: loader waits until the lock drops.
    gseq.delete();
    lock_mode = 1'b1;
    for (int i = 0; i < 6; i++) cq.push_back(rand_txn());
    for (int i = 0; i < 3; i++) lq.push_back(rand_txn());
    drain(100);
    lock_mode = 1'b0; lock_v = 1'b0;
    check("lock_n", 32'(gseq.size()), 32'd9);
    for (int i = 0; i < 6; i++) check("lock_c", 32'(gseq[i]), 32'd0);
    check("lock_l_after", 32'(gseq[6]), 32'd1);

    // Random traffic with random lock.
    rnd_on = 1'b1;
    repeat (800) tick();
    rnd_on = 1'b0; lock_v = 1'b0;
    drain(200);

    // MEM_LAT=3 instance: core read of 0x0020.
    @(negedge clock);
    b3.c_req = 1; b3.c_we = 0; b3.c_addr = 16'h0020;
    @(negedge clock);
    check("l3_gnt", 32'(b3.c_gnt), 32'd1);
    check("l3_en", 32'(b3.mem_en), 32'd1);
    check("l3_busy_issue", 32'(b3.busy), 32'd1);
    b3.c_req = 0;
    @(negedge clock);
    check("l3_wait_en", 32'(b3.mem_en), 32'd0);
    check("l3_busy_w1", 32'(b3.busy), 32'd1);
    check("l3_early_done1", 32'(b3.c_done), 32'd0);
    @(negedge clock);
    check("l3_busy_w2", 32'(b3.busy), 32'd1);
    check("l3_early_done2", 32'(b3.c_done), 32'd0);
    @(negedge clock);
    check("l3_done", 32'(b3.c_done), 32'd1);
    check("l3_rdata", 32'(b3.rdata), 32'h6A);
    check("l3_busy_resp", 32'(b3.busy), 32'd0);
    @(negedge clock);
    check("l3_done_pulse", 32'(b3.c_done), 32'd0);

    // Reset asserted during WAIT.
    b3.c_req = 1; b3.c_addr = 16'h0021;
    @(negedge clock);
    check("rw_gnt", 32'(b3.c_gnt), 32'd1);
    b3.c_req = 0;
    @(negedge clock);
    check("rw_in_wait", 32'(b3.busy), 32'd1);
    #2 rst3_n = 1'b0;
    #1;
    check("rw_busy", 32'(b3.busy), 32'd0);
    check("rw_mem_en", 32'(b3.mem_en), 32'd0);
    check("rw_done", 32'({b3.c_done, b3.l_done}), 32'd0);
    repeat (2) begin
      @(negedge clock);
      check("rw_hold_done", 32'({b3.c_done, b3.l_done}), 32'd0);
    end
    rst3_n = 1'b1;
    @(negedge clock);
    check("rw_no_done", 32'({b3.c_done, b3.l_done}), 32'd0);
    check("rw_idle", 32'(b3.busy), 32'd0);
    b3.c_req = 1; b3.l_req = 1; b3.l_addr = 16'h0030;
    @(negedge clock);
    check("rw_tie_c", 32'(b3.c_gnt), 32'd1);
    check("rw_tie_l", 32'(b3.l_gnt), 32'd0);
    b3.c_req = 0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (b3.l_gnt) seen = 1'b1;
    end
    check("rw_l_next", 32'(seen), 32'd1);
    b3.l_req = 0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor core (microcoded control unit, port C) and the external image loader/unloader (port L).
- Arbitrates round-robin, with a core lock for multi-step instruction sequences.
- Sequences each access through a fixed memory read latency and returns read data and a per-port completion pulse.
- Sits between the control-unit/datapath memory interface and the data RAM.

Parameters:
- AW, 16, address width
- DW, 8, data width
- MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal 1..4

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- c_req  in  1  core request; held until c_gnt
- c_we  in  1  core write enable (1=write, 0=read)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_lock  in  1  while high, port L is never granted
- c_gnt  out  1  one-cycle pulse: core request accepted
- c_done  out  1  one-cycle pulse: core access complete
- l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  loader equivalents of the core inputs
- l_gnt, l_done  out  1/1  loader equivalents of c_gnt, c_done
- rdata  out  DW  read data, valid while the matching *_done is high for a read
- busy  out  1  high in ISSUE and WAIT
- mem_en, mem_we  out  1/1  RAM strobe and write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data

Behaviour:
- All outputs registered. Reset values:
  - all outputs 0
  - state IDLE
  - round-robin pointer last=L, so the core wins the first tie
- Reset is asynchronous: asserting reset_n mid-transaction drops mem_en and busy immediately; the transaction is lost, no done is issued, and the requester must reissue.
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration runs only in IDLE and RESP; req inputs are ignored in ISSUE and WAIT.
- Winner selection:
  - c_lock=1: only the core is eligible.
  - Otherwise, if one port requests, it wins.
  - If both request, the port not granted last wins.
- On the arbitration edge:
  - latch owner, we, addr and wdata
  - update the pointer
  - next state ISSUE
  - assert owner's gnt for exactly the ISSUE cycle
- Requester rules:
  - Hold req and the request fields stable until gnt is seen.
  - Deassert req in the gnt cycle, or the arbiter treats it as a new request at the next arbitration point.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
  - Write: next state RESP.
  - Read with MEM_LAT=1: next state RESP.
  - Read with MEM_LAT>1: next state WAIT with counter = MEM_LAT-1.
- WAIT: mem_en=0; counter decrements each cycle; at counter=1 the next state is RESP.
- Read data capture: mem_rdata is sampled into rdata on the edge that enters RESP.
- RESP (1 cycle):
  - owner's done=1; rdata valid if the access was a read, and rdata is held until the next read completes.
  - Arbitration is performed in this cycle, so back-to-back accesses are possible.
  - Next state is ISSUE if a winner exists, else IDLE.
- Latency:
  - Write: gnt cycle = ISSUE; done 1 cycle later.
  - Read: done MEM_LAT cycles after ISSUE.
  - Minimum per-access period: 2 cycles for writes, MEM_LAT+1 cycles for reads.
- c_lock changes take effect at the next arbitration point; an in-flight loader access always completes.
- Address and data widths pass through unchanged; there is no range checking.

Test Plan:
- Core read, MEM_LAT=1, RAM[0x0010]=0x5A:
  - c_req at cycle 0 -> c_gnt and mem_en at cycle 1; c_done=1 and rdata=0x5A at cycle 2; l_gnt stays 0.
- Loader write 0x3C to 0x0100, then core read of 0x0100 -> RAM holds 0x3C; core rdata=0x3C; writes take 2 cycles each.
- Both request continuously, c_lock=0 -> grants alternate C,L,C,L starting with C after reset; no port is granted twice in a row.
- c_lock=1 with both requesting for 6 accesses -> only c_gnt pulses; l_gnt first pulses at the arbitration point after c_lock falls.
- MEM_LAT=3 core read -> WAIT for 2 cycles; c_done 3 cycles after ISSUE; busy high for 3 cycles.
- reset_n low during WAIT -> mem_en, busy and done go to 0 immediately; after release, the first tie is won by the core.
